// File: rtl/rv_pipe_pkg.sv
// Shared types for the RV32I pipeline: ALU operation codes, forwarding source
// select, and the ID/EX pipeline register layout.
package rv_pipe_pkg;

  localparam int DATA_WIDTH    = 32;
  localparam int OPCODE_LENGTH = 4;
  localparam int REG_ADDR_W    = 5;

  localparam logic [OPCODE_LENGTH-1:0] ALU_AND  = 4'b0000;
  localparam logic [OPCODE_LENGTH-1:0] ALU_OR   = 4'b0001;
  localparam logic [OPCODE_LENGTH-1:0] ALU_ADD  = 4'b0010;
  localparam logic [OPCODE_LENGTH-1:0] ALU_SUB  = 4'b0011;
  localparam logic [OPCODE_LENGTH-1:0] ALU_BEQ  = 4'b1000;
  localparam logic [OPCODE_LENGTH-1:0] ALU_SRLI = 4'b1001;

  typedef enum logic [1:0] {
    FWD_RF    = 2'd0,
    FWD_MEMWB = 2'd1,
    FWD_EXMEM = 2'd2
  } fwd_sel_t;

  typedef struct packed {
    logic                     valid;
    logic [REG_ADDR_W-1:0]    rs1;
    logic [REG_ADDR_W-1:0]    rs2;
    logic [REG_ADDR_W-1:0]    rd;
    logic [DATA_WIDTH-1:0]    rs1_data;
    logic [DATA_WIDTH-1:0]    rs2_data;
    logic [DATA_WIDTH-1:0]    imm;
    logic                     alu_src;
    logic [OPCODE_LENGTH-1:0] alu_op;
    logic                     mem_read;
    logic                     reg_write;
  } id_ex_t;

  // A writeback source may only satisfy a read of a nonzero register it actually writes.
  function automatic logic wb_hits(input logic                  wb_write,
                                   input logic [REG_ADDR_W-1:0] wb_rd,
                                   input logic [REG_ADDR_W-1:0] rs);
    return wb_write && (wb_rd != '0) && (wb_rd == rs);
  endfunction

endpackage

// File: rtl/fwd_unit.sv
// Per-operand forwarding selector: picks the youngest in-flight writeback that
// targets the operand's register, otherwise leaves the register-file value.
module fwd_unit
  import rv_pipe_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] rs,
  input  logic [REG_ADDR_W-1:0] exmem_rd,
  input  logic                  exmem_reg_write,
  input  logic [DATA_WIDTH-1:0] exmem_result,
  input  logic [REG_ADDR_W-1:0] memwb_rd,
  input  logic                  memwb_reg_write,
  input  logic [DATA_WIDTH-1:0] memwb_result,
  output fwd_sel_t              sel,
  output logic [DATA_WIDTH-1:0] value
);

  // EX/MEM is younger than MEM/WB, so it takes precedence on a double hit.
  always_comb begin
    sel   = FWD_RF;
    value = '0;
    if (wb_hits(exmem_reg_write, exmem_rd, rs)) begin
      sel   = FWD_EXMEM;
      value = exmem_result;
    end else if (wb_hits(memwb_reg_write, memwb_rd, rs)) begin
      sel   = FWD_MEMWB;
      value = memwb_result;
    end
  end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with EX-side operand forwarding and load-use stall
// generation; feeds the ALU directly.
module id_ex_operand_stage
  import rv_pipe_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4,
  parameter int REG_ADDR_W    = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     id_valid,
  input  logic [REG_ADDR_W-1:0]    id_rs1,
  input  logic [REG_ADDR_W-1:0]    id_rs2,
  input  logic [REG_ADDR_W-1:0]    id_rd,
  input  logic [DATA_WIDTH-1:0]    id_rs1_data,
  input  logic [DATA_WIDTH-1:0]    id_rs2_data,
  input  logic [DATA_WIDTH-1:0]    id_imm,
  input  logic                     id_alu_src,
  input  logic                     id_uses_rs2,
  input  logic [OPCODE_LENGTH-1:0] id_alu_op,
  input  logic                     id_mem_read,
  input  logic                     id_reg_write,
  input  logic                     flush,
  input  logic [REG_ADDR_W-1:0]    exmem_rd,
  input  logic                     exmem_reg_write,
  input  logic [DATA_WIDTH-1:0]    exmem_result,
  input  logic [REG_ADDR_W-1:0]    memwb_rd,
  input  logic                     memwb_reg_write,
  input  logic [DATA_WIDTH-1:0]    memwb_result,
  output logic                     stall,
  output logic [DATA_WIDTH-1:0]    src_a,
  output logic [DATA_WIDTH-1:0]    src_b,
  output logic [OPCODE_LENGTH-1:0] alu_operation,
  output logic [DATA_WIDTH-1:0]    ex_store_data,
  output logic                     ex_valid,
  output logic [REG_ADDR_W-1:0]    ex_rd,
  output logic                     ex_mem_read,
  output logic                     ex_reg_write
);

  id_ex_t                ex_q;
  id_ex_t                ex_d;
  logic                  hz;
  fwd_sel_t              sel_a;
  fwd_sel_t              sel_b;
  logic [DATA_WIDTH-1:0] wb_val_a;
  logic [DATA_WIDTH-1:0] wb_val_b;
  logic [DATA_WIDTH-1:0] rs2_fwd;

  // A load in EX cannot forward its data yet, so a dependent ID instruction must wait.
  always_comb begin
    hz = id_valid && ex_q.valid && ex_q.mem_read && (ex_q.rd != '0) &&
         ((id_rs1 == ex_q.rd) || (id_uses_rs2 && (id_rs2 == ex_q.rd)));
    stall = hz && !flush && !reset;
  end

  always_comb begin
    ex_d           = '0;
    ex_d.valid     = id_valid;
    ex_d.rs1       = id_rs1;
    ex_d.rs2       = id_rs2;
    ex_d.rd        = id_rd;
    ex_d.rs1_data  = id_rs1_data;
    ex_d.rs2_data  = id_rs2_data;
    ex_d.imm       = id_imm;
    ex_d.alu_src   = id_alu_src;
    ex_d.alu_op    = id_alu_op;
    ex_d.mem_read  = id_mem_read;
    ex_d.reg_write = id_reg_write;
  end

  // Flush and hazard both insert a fully cleared bubble rather than holding EX.
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q <= '0;
    end else if (flush || hz) begin
      ex_q <= '0;
    end else begin
      ex_q <= ex_d;
    end
  end

  fwd_unit #(
    .DATA_WIDTH (DATA_WIDTH),
    .REG_ADDR_W (REG_ADDR_W)
  ) u_fwd_a (
    .rs              (ex_q.rs1),
    .exmem_rd        (exmem_rd),
    .exmem_reg_write (exmem_reg_write),
    .exmem_result    (exmem_result),
    .memwb_rd        (memwb_rd),
    .memwb_reg_write (memwb_reg_write),
    .memwb_result    (memwb_result),
    .sel             (sel_a),
    .value           (wb_val_a)
  );

  fwd_unit #(
    .DATA_WIDTH (DATA_WIDTH),
    .REG_ADDR_W (REG_ADDR_W)
  ) u_fwd_b (
    .rs              (ex_q.rs2),
    .exmem_rd        (exmem_rd),
    .exmem_reg_write (exmem_reg_write),
    .exmem_result    (exmem_result),
    .memwb_rd        (memwb_rd),
    .memwb_reg_write (memwb_reg_write),
    .memwb_result    (memwb_result),
    .sel             (sel_b),
    .value           (wb_val_b)
  );

  always_comb begin
    src_a   = (sel_a == FWD_RF) ? ex_q.rs1_data : wb_val_a;
    rs2_fwd = (sel_b == FWD_RF) ? ex_q.rs2_data : wb_val_b;
    src_b   = ex_q.alu_src ? ex_q.imm : rs2_fwd;
  end

  assign ex_store_data = rs2_fwd;
  assign alu_operation = ex_q.alu_op;
  assign ex_valid      = ex_q.valid;
  assign ex_rd         = ex_q.rd;
  assign ex_mem_read   = ex_q.mem_read;
  assign ex_reg_write  = ex_q.reg_write;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Self-checking bench for id_ex_operand_stage: directed scenarios plus random
// traffic, all compared against a cycle-level behavioural model of the stage.
module tb_id_ex_operand_stage;
  import rv_pipe_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid, id_alu_src, id_uses_rs2, id_mem_read, id_reg_write, flush;
  logic [4:0]  id_rs1, id_rs2, id_rd, exmem_rd, memwb_rd;
  logic [31:0] id_rs1_data, id_rs2_data, id_imm, exmem_result, memwb_result;
  logic [3:0]  id_alu_op;
  logic        exmem_reg_write, memwb_reg_write;
  logic        stall, ex_valid, ex_mem_read, ex_reg_write;
  logic [31:0] src_a, src_b, ex_store_data;
  logic [3:0]  alu_operation;
  logic [4:0]  ex_rd;

  int total = 0;
  int bad   = 0;

  // Model of the instruction currently sitting in EX
  logic        m_valid, m_alu_src, m_mem_read, m_reg_write;
  logic [4:0]  m_rs1, m_rs2, m_rd;
  logic [31:0] m_d1, m_d2, m_imm;
  logic [3:0]  m_op;

  always #5 clk = ~clk;

  id_ex_operand_stage dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rd(id_rd), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_alu_src(id_alu_src), .id_uses_rs2(id_uses_rs2), .id_alu_op(id_alu_op),
    .id_mem_read(id_mem_read), .id_reg_write(id_reg_write), .flush(flush),
    .exmem_rd(exmem_rd), .exmem_reg_write(exmem_reg_write), .exmem_result(exmem_result),
    .memwb_rd(memwb_rd), .memwb_reg_write(memwb_reg_write), .memwb_result(memwb_result),
    .stall(stall), .src_a(src_a), .src_b(src_b), .alu_operation(alu_operation),
    .ex_store_data(ex_store_data), .ex_valid(ex_valid), .ex_rd(ex_rd),
    .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] refFwd(input logic [4:0] r, input logic [31:0] rf);
    if (exmem_reg_write && exmem_rd != 0 && exmem_rd == r) return exmem_result;
    if (memwb_reg_write && memwb_rd != 0 && memwb_rd == r) return memwb_result;
    return rf;
  endfunction

  function automatic logic refHazard();
    return id_valid && m_valid && m_mem_read && m_rd != 0 &&
           (id_rs1 == m_rd || (id_uses_rs2 && id_rs2 == m_rd));
  endfunction

  task automatic clearModel();
    {m_valid, m_alu_src, m_mem_read, m_reg_write} = '0;
    {m_rs1, m_rs2, m_rd, m_op} = '0;
    {m_d1, m_d2, m_imm} = '0;
  endtask

  task automatic checkModel();
    logic [31:0] f2;
    f2 = refFwd(m_rs2, m_d2);
    checkOutput("stall", stall, refHazard() && !flush && !reset);
    checkOutput("ex_valid", ex_valid, m_valid);
    checkOutput("ex_rd", ex_rd, m_rd);
    checkOutput("ex_mem_read", ex_mem_read, m_mem_read);
    checkOutput("ex_reg_write", ex_reg_write, m_reg_write);
    checkOutput("alu_operation", alu_operation, m_op);
    checkOutput("src_a", src_a, refFwd(m_rs1, m_d1));
    checkOutput("ex_store_data", ex_store_data, f2);
    checkOutput("src_b", src_b, m_alu_src ? m_imm : f2);
  endtask

  // Check the current cycle, advance the model by one clock, then move past the edge.
  task automatic stepClock();
    #3;
    checkModel();
    if (reset || flush || refHazard()) begin
      clearModel();
    end else begin
      m_valid = id_valid; m_rs1 = id_rs1; m_rs2 = id_rs2; m_rd = id_rd;
      m_d1 = id_rs1_data; m_d2 = id_rs2_data; m_imm = id_imm; m_alu_src = id_alu_src;
      m_op = id_alu_op; m_mem_read = id_mem_read; m_reg_write = id_reg_write;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic [4:0] rd, input logic [31:0] d1, input logic [31:0] d2,
                               input logic [31:0] imm, input logic asrc, input logic u2,
                               input logic [3:0] op, input logic mr, input logic rw);
    id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd; id_rs1_data = d1;
    id_rs2_data = d2; id_imm = imm; id_alu_src = asrc; id_uses_rs2 = u2;
    id_alu_op = op; id_mem_read = mr; id_reg_write = rw;
  endtask

  task automatic clearWb();
    exmem_rd = 0; exmem_reg_write = 0; exmem_result = 0;
    memwb_rd = 0; memwb_reg_write = 0; memwb_result = 0;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0;
    clearWb();
    applyStimulus(1, 1, 2, 3, 32'h11, 32'h22, 32'h33, 0, 1, ALU_ADD, 0, 1);
    @(posedge clk);
    #1;
    clearModel();

    // Reset held with a valid instruction waiting in ID
    stepClock();
    stepClock();
    checkOutput("rst_ex_valid", ex_valid, 0);
    checkOutput("rst_src_a", src_a, 0);
    reset = 1'b0;

    // Plain ADD x?, x1, x2
    applyStimulus(1, 1, 2, 4, 32'd5, 32'd7, 32'h0, 0, 1, ALU_ADD, 0, 1);
    stepClock();
    checkOutput("add_src_a", src_a, 32'd5);
    checkOutput("add_src_b", src_b, 32'd7);
    checkOutput("add_op", alu_operation, 4'b0010);

    // Forwarding priority on rs1=x1
    exmem_rd = 1; exmem_reg_write = 1; exmem_result = 32'h10;
    memwb_rd = 1; memwb_reg_write = 1; memwb_result = 32'h20;
    #1 checkOutput("fwd_exmem", src_a, 32'h10);
    exmem_reg_write = 0;
    #1 checkOutput("fwd_memwb", src_a, 32'h20);
    exmem_reg_write = 1; exmem_rd = 0; memwb_rd = 0;
    #1 checkOutput("fwd_x0", src_a, 32'd5);
    clearWb();

    // Load-use: LW x3 then ADD x4, x3, x5
    applyStimulus(1, 1, 0, 3, 32'h100, 32'h0, 32'h8, 1, 0, ALU_ADD, 1, 1);
    stepClock();
    applyStimulus(1, 3, 5, 4, 32'hDEAD, 32'h9, 32'h0, 0, 1, ALU_ADD, 0, 1);
    #1 checkOutput("lu_stall", stall, 1);
    stepClock();
    checkOutput("lu_bubble", ex_valid, 0);
    checkOutput("lu_stall_released", stall, 0);
    stepClock();
    memwb_rd = 3; memwb_reg_write = 1; memwb_result = 32'hABCD;
    #1 checkOutput("lu_fwd", src_a, 32'hABCD);
    clearWb();

    // Back-to-back loads: LW x6 then LW x7, 0(x6)
    applyStimulus(1, 1, 0, 6, 32'h200, 32'h0, 32'h4, 1, 0, ALU_ADD, 1, 1);
    stepClock();
    applyStimulus(1, 6, 0, 7, 32'h0, 32'h0, 32'h0, 1, 0, ALU_ADD, 1, 1);
    #1 checkOutput("ll_stall", stall, 1);
    stepClock();
    checkOutput("ll_stall_once", stall, 0);
    stepClock();
    checkOutput("ll_second_load", ex_mem_read, 1);

    // Flush coinciding with a load-use hazard
    applyStimulus(1, 1, 0, 3, 32'h100, 32'h0, 32'h8, 1, 0, ALU_ADD, 1, 1);
    stepClock();
    applyStimulus(1, 3, 5, 4, 32'h1, 32'h2, 32'h0, 0, 1, ALU_SUB, 0, 1);
    flush = 1'b1;
    #1 checkOutput("fl_stall", stall, 0);
    stepClock();
    flush = 1'b0;
    checkOutput("fl_reg_write", ex_reg_write, 0);
    checkOutput("fl_valid", ex_valid, 0);

    // Reset asserted while stalled
    applyStimulus(1, 1, 0, 3, 32'h100, 32'h0, 32'h8, 1, 0, ALU_ADD, 1, 1);
    stepClock();
    applyStimulus(1, 3, 5, 4, 32'h1, 32'h2, 32'h0, 0, 1, ALU_OR, 0, 1);
    reset = 1'b1;
    #1 checkOutput("rs_stall", stall, 0);
    stepClock();
    reset = 1'b0;
    checkOutput("rs_bubble", ex_valid, 0);

    // Immediate operand with forwarded rs2
    applyStimulus(1, 1, 2, 8, 32'd3, 32'd7, 32'hFFFF_FFFC, 1, 1, ALU_ADD, 0, 0);
    stepClock();
    exmem_rd = 2; exmem_reg_write = 1; exmem_result = 32'h55;
    #1 checkOutput("imm_src_b", src_b, 32'hFFFF_FFFC);
    checkOutput("imm_store", ex_store_data, 32'h55);
    clearWb();

    // Random traffic over a small register window so hazards and hits are common
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 49) == 0);
      flush = ($urandom_range(0, 9) == 0);
      applyStimulus($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                    5'($urandom_range(0, 7)), $urandom, $urandom, $urandom,
                    1'($urandom), 1'($urandom), 4'($urandom), $urandom_range(0, 2) == 0,
                    1'($urandom));
      exmem_rd = 5'($urandom_range(0, 7)); exmem_reg_write = 1'($urandom); exmem_result = $urandom;
      memwb_rd = 5'($urandom_range(0, 7)); memwb_reg_write = 1'($urandom); memwb_result = $urandom;
      stepClock();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
